// File: rtl/store_pkg.sv
// store_pkg: shared definitions for the store queue.
//   - funct3 encodings for SB/SH/SW
//   - byte-strobe constants used by the lane aligner
//   - sq_entry_t: one buffered, already-formatted memory write
//   - word_to_byte_addr: expands a stored word address to a byte address
package store_pkg;

  localparam logic [2:0] F3_SB = 3'd0;
  localparam logic [2:0] F3_SH = 3'd1;
  localparam logic [2:0] F3_SW = 3'd2;

  localparam logic [3:0] STRB_BYTE0   = 4'b0001;
  localparam logic [3:0] STRB_LO_HALF = 4'b0011;
  localparam logic [3:0] STRB_HI_HALF = 4'b1100;
  localparam logic [3:0] STRB_WORD    = 4'b1111;

  // Only the word address is kept; the byte offset is fully encoded in the strobe.
  typedef struct packed {
    logic [29:0] word_addr;
    logic [31:0] data;
    logic [3:0]  strobe;
  } sq_entry_t;

  function automatic logic [31:0] word_to_byte_addr(input logic [29:0] word_addr);
    return {word_addr, 2'b00};
  endfunction

endpackage

// File: rtl/store_lane_align.sv
// store_lane_align: combinational store formatter.
//   funct3_i   in  3   SB/SH/SW selector
//   addr_lo_i  in  2   byte offset within the word (store_address[1:0])
//   value_i    in  32  raw rs2 value
//   strobe_o   out 4   byte enables, bit i = byte lane i
//   data_o     out 32  value replicated so the selected lanes carry it
//   error_o    out 1   misaligned half/word or illegal funct3
module store_lane_align
  import store_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] value_i,
  output logic [3:0]  strobe_o,
  output logic [31:0] data_o,
  output logic        error_o
);

  always_comb begin
    strobe_o = 4'b0000;
    data_o   = 32'h0;
    error_o  = 1'b0;
    case (funct3_i)
      F3_SB: begin
        strobe_o = STRB_BYTE0 << addr_lo_i;
        data_o   = {4{value_i[7:0]}};
      end
      F3_SH: begin
        if (addr_lo_i[0]) begin
          error_o = 1'b1;
        end else begin
          strobe_o = addr_lo_i[1] ? STRB_HI_HALF : STRB_LO_HALF;
          data_o   = {2{value_i[15:0]}};
        end
      end
      F3_SW: begin
        if (addr_lo_i != 2'b00) begin
          error_o = 1'b1;
        end else begin
          strobe_o = STRB_WORD;
          data_o   = value_i;
        end
      end
      default: error_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_queue.sv
// store_queue: FIFO of formatted stores draining to data memory.
//   clock, reset_n                 clock / async active-low reset
//   store_valid, store_ready       store request handshake (ready = not full)
//   funct3, store_address,
//   store_value                    store request payload
//   mem_write_request, mem_write_ack
//                                  head-entry write handshake (pop on req && ack)
//   mem_write_address/data/strobe  head entry, all zero while empty
//   load_check_address, load_hazard
//                                  load word overlaps any pending entry
//   store_error                    one-cycle pulse after a dropped bad store
//   queue_empty                    no pending entries
module store_queue
  import store_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        store_valid,
  output logic        store_ready,
  input  logic [2:0]  funct3,
  input  logic [31:0] store_address,
  input  logic [31:0] store_value,
  output logic        mem_write_request,
  input  logic        mem_write_ack,
  output logic [31:0] mem_write_address,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_write_strobe,
  input  logic [31:0] load_check_address,
  output logic        load_hazard,
  output logic        store_error,
  output logic        queue_empty
);

  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] ONE_COUNT  = (DEPTH_LOG2 + 1)'(1);

  sq_entry_t               entry_q [DEPTH];
  logic [DEPTH-1:0]        valid_q;
  logic [DEPTH_LOG2-1:0]   head_q, head_d;
  logic [DEPTH_LOG2-1:0]   tail_q, tail_d;
  logic [DEPTH_LOG2:0]     count_q, count_d;
  logic                    error_q;

  logic [3:0]  fmt_strobe;
  logic [31:0] fmt_data;
  logic        fmt_error;
  logic        accept, push, pop;
  sq_entry_t   new_entry, head_entry;

  store_lane_align u_align (
    .funct3_i  (funct3),
    .addr_lo_i (store_address[1:0]),
    .value_i   (store_value),
    .strobe_o  (fmt_strobe),
    .data_o    (fmt_data),
    .error_o   (fmt_error)
  );

  assign store_ready = (count_q != FULL_COUNT);
  assign queue_empty = (count_q == '0);

  // A bad store still completes the handshake; it just never reaches the array.
  assign accept = store_valid && store_ready;
  assign push   = accept && !fmt_error;
  assign pop    = mem_write_request && mem_write_ack;

  assign new_entry = '{word_addr: store_address[31:2], data: fmt_data, strobe: fmt_strobe};

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + 1'b1;
    if (pop)  head_d = head_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + ONE_COUNT;
      2'b01:   count_d = count_q - ONE_COUNT;
      default: count_d = count_q;
    endcase
  end

  // Push and pop never target the same slot: pop needs a non-empty queue and
  // push needs a non-full one, so head == tail cannot coincide with both.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      error_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      error_q <= accept && fmt_error;
      if (push) begin
        entry_q[tail_q] <= new_entry;
        valid_q[tail_q] <= 1'b1;
      end
      if (pop) valid_q[head_q] <= 1'b0;
    end
  end

  assign store_error = error_q;

  // Popped slots keep stale contents, so the outputs are gated on empty.
  assign head_entry        = entry_q[head_q];
  assign mem_write_request = !queue_empty;
  assign mem_write_address = queue_empty ? 32'h0 : word_to_byte_addr(head_entry.word_addr);
  assign mem_write_data    = queue_empty ? 32'h0 : head_entry.data;
  assign mem_write_strobe  = queue_empty ? 4'b0000 : head_entry.strobe;

  // Hazard compare at word granularity; this cycle's incoming store is not yet in valid_q.
  logic [DEPTH-1:0] hit;
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_hazard
      assign hit[gi] = valid_q[gi] && (entry_q[gi].word_addr == load_check_address[31:2]);
    end
  endgenerate
  assign load_hazard = |hit;

  logic unused_load_offset;
  assign unused_load_offset = ^load_check_address[1:0];

endmodule

// File: tb/tb_store_queue.sv
module tb_store_queue;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        store_valid;
  logic        store_ready;
  logic [2:0]  funct3;
  logic [31:0] store_address;
  logic [31:0] store_value;
  logic        mem_write_request;
  logic        mem_write_ack;
  logic [31:0] mem_write_address;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_write_strobe;
  logic [31:0] load_check_address;
  logic        load_hazard;
  logic        store_error;
  logic        queue_empty;

  always #5 clock = ~clock;

  store_queue #(.DEPTH(4), .DEPTH_LOG2(2)) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .store_valid        (store_valid),
    .store_ready        (store_ready),
    .funct3             (funct3),
    .store_address      (store_address),
    .store_value        (store_value),
    .mem_write_request  (mem_write_request),
    .mem_write_ack      (mem_write_ack),
    .mem_write_address  (mem_write_address),
    .mem_write_data     (mem_write_data),
    .mem_write_strobe   (mem_write_strobe),
    .load_check_address (load_check_address),
    .load_hazard        (load_hazard),
    .store_error        (store_error),
    .queue_empty        (queue_empty)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  task automatic expect_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    exp_q.push_back('{addr: a, data: d, strb: s});
  endtask

  // Presents one store for a single cycle; returns 1ns after that edge.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] v);
    store_valid   = 1'b1;
    funct3        = f3;
    store_address = a;
    store_value   = v;
    tick();
    store_valid   = 1'b0;
  endtask

  task automatic drain(input int n);
    mem_write_ack = 1'b1;
    repeat (n) tick();
    mem_write_ack = 1'b0;
  endtask

  // Scoreboard monitor: sampled on the falling edge, where req && ack means
  // the head pops on the following rising edge.
  always @(negedge clock) begin
    if (reset_n && mem_write_request && mem_write_ack) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h strobe %b, required no write",
                 mem_write_address, mem_write_data, mem_write_strobe);
      end else begin
        mon_e = exp_q.pop_front();
        if (mem_write_address !== mon_e.addr || mem_write_data !== mon_e.data ||
            mem_write_strobe !== mon_e.strb) begin
          errors++;
          $display("FAIL mem_write: got addr 0x%08h data 0x%08h strobe %b, required addr 0x%08h data 0x%08h strobe %b",
                   mem_write_address, mem_write_data, mem_write_strobe,
                   mon_e.addr, mon_e.data, mon_e.strb);
        end else begin
          $display("write addr=0x%08h data=0x%08h strobe=%b", mem_write_address, mem_write_data,
                   mem_write_strobe);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required finish before 200000ns");
    $fatal(1);
  end

  initial begin
    reset_n            = 1'b0;
    store_valid        = 1'b0;
    funct3             = 3'd0;
    store_address      = 32'h0;
    store_value        = 32'h0;
    mem_write_ack      = 1'b0;
    load_check_address = 32'h0;
    repeat (2) tick();

    // Reset state
    chk("reset_ready", 32'(store_ready), 32'd1);
    chk("reset_empty", 32'(queue_empty), 32'd1);
    chk("reset_request", 32'(mem_write_request), 32'd0);
    chk("reset_address", mem_write_address, 32'h0);
    chk("reset_data", mem_write_data, 32'h0);
    chk("reset_strobe", 32'(mem_write_strobe), 32'h0);
    chk("reset_error", 32'(store_error), 32'd0);
    reset_n = 1'b1;
    tick();

    // SB to byte 3 lands in lane 3, request visible right after the accept edge
    expect_write(32'h100, 32'hDDDDDDDD, 4'b1000);
    issue(3'd0, 32'h103, 32'hAABBCCDD);
    chk("sb_request", 32'(mem_write_request), 32'd1);
    chk("sb_empty", 32'(queue_empty), 32'd0);
    drain(1);
    chk("sb_drained_empty", 32'(queue_empty), 32'd1);
    chk("empty_address_zero", mem_write_address, 32'h0);

    // SH upper half, then misaligned SH dropped with an error pulse
    expect_write(32'h200, 32'h12341234, 4'b1100);
    issue(3'd1, 32'h202, 32'h00001234);
    chk("sh_ok_no_error", 32'(store_error), 32'd0);
    issue(3'd1, 32'h201, 32'h00005678);
    chk("sh_misaligned_error", 32'(store_error), 32'd1);
    tick();
    chk("sh_error_one_cycle", 32'(store_error), 32'd0);
    drain(1);
    chk("sh_misaligned_not_queued", 32'(queue_empty), 32'd1);

    // Illegal funct3 and misaligned SW
    issue(3'd3, 32'h300, 32'h1);
    chk("f3_illegal_error", 32'(store_error), 32'd1);
    issue(3'd2, 32'h1002, 32'h2);
    chk("sw_misaligned_error", 32'(store_error), 32'd1);
    chk("bad_stores_not_queued", 32'(queue_empty), 32'd1);
    tick();
    chk("error_cleared", 32'(store_error), 32'd0);

    // Fill with four SWs, no ack
    for (int i = 0; i < 4; i++) begin
      expect_write(32'h1000 + 32'(4 * i), 32'hC0DE0000 + 32'(i), 4'b1111);
      issue(3'd2, 32'h1000 + 32'(4 * i), 32'hC0DE0000 + 32'(i));
      chk("fill_ready", 32'(store_ready), (i < 3) ? 32'd1 : 32'd0);
    end
    // Store presented while full must not be taken
    issue(3'd2, 32'h2000, 32'hDEADBEEF);
    chk("full_stays_not_ready", 32'(store_ready), 32'd0);
    drain(1);
    chk("ready_after_pop", 32'(store_ready), 32'd1);
    drain(3);
    chk("fill_drained_empty", 32'(queue_empty), 32'd1);

    // Hazard on word overlap
    expect_write(32'h40, 32'h00000055, 4'b1111);
    issue(3'd2, 32'h40, 32'h00000055);
    load_check_address = 32'h43;
    #1;
    chk("hazard_hit", 32'(load_hazard), 32'd1);
    load_check_address = 32'h44;
    #1;
    chk("hazard_other_word", 32'(load_hazard), 32'd0);
    load_check_address = 32'h43;
    drain(1);
    chk("hazard_after_ack", 32'(load_hazard), 32'd0);

    // Store being accepted this cycle is not yet a hazard
    load_check_address = 32'h80;
    store_valid   = 1'b1;
    funct3        = 3'd2;
    store_address = 32'h80;
    store_value   = 32'h66;
    expect_write(32'h80, 32'h66, 4'b1111);
    #1;
    chk("hazard_same_cycle", 32'(load_hazard), 32'd0);
    tick();
    store_valid = 1'b0;
    chk("hazard_next_cycle", 32'(load_hazard), 32'd1);
    drain(1);

    // Simultaneous push and pop with two entries pending
    expect_write(32'h300, 32'hA0, 4'b1111);
    issue(3'd2, 32'h300, 32'hA0);
    expect_write(32'h304, 32'hA1, 4'b1111);
    issue(3'd2, 32'h304, 32'hA1);
    expect_write(32'h308, 32'hA2, 4'b1111);
    mem_write_ack = 1'b1;
    issue(3'd2, 32'h308, 32'hA2);
    mem_write_ack = 1'b0;
    chk("pushpop_next_head", mem_write_address, 32'h304);
    expect_write(32'h30C, 32'hA3, 4'b1111);
    issue(3'd2, 32'h30C, 32'hA3);
    chk("pushpop_count3_ready", 32'(store_ready), 32'd1);
    expect_write(32'h310, 32'hA4, 4'b1111);
    issue(3'd2, 32'h310, 32'hA4);
    chk("pushpop_count4_full", 32'(store_ready), 32'd0);
    drain(4);
    chk("pushpop_drained", 32'(queue_empty), 32'd1);

    // Reset mid-drain with three entries left
    for (int i = 0; i < 4; i++) begin
      expect_write(32'h500 + 32'(4 * i), 32'hB0 + 32'(i), 4'b1111);
      issue(3'd2, 32'h500 + 32'(4 * i), 32'hB0 + 32'(i));
    end
    drain(1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_empty", 32'(queue_empty), 32'd1);
    chk("async_reset_request", 32'(mem_write_request), 32'd0);
    chk("async_reset_strobe", 32'(mem_write_strobe), 32'h0);
    chk("async_reset_ready", 32'(store_ready), 32'd1);
    exp_q.delete();
    tick();
    reset_n = 1'b1;
    tick();

    // Queue usable after reset: SB to byte 1
    expect_write(32'h600, 32'h77777777, 4'b0010);
    issue(3'd0, 32'h601, 32'h00000077);
    chk("post_reset_strobe", 32'(mem_write_strobe), 32'h2);
    drain(1);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("final_empty", 32'(queue_empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
